coin_acceptor: RTL and testbench
================================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive stable synchronized samples required before the debounced level changes.
REQ-002 Parameter W10_MIN/W10_MAX, default 8/15: debounced high-width range, in cycles, classified as a ten coin.
REQ-003 Parameter W20_MIN/W20_MAX, default 16/31: width range classified as a twenty coin.
REQ-004 Parameter W50_MIN/W50_MAX, default 32/63: width range classified as a fifty coin.
REQ-005 Parameter GAP_CYCLES, default 8: cooldown length after each classification, in cycles.
REQ-006 clock  input  1  single system clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 sense  input  1  raw coin-gate sensor; asynchronous to clock; high while a coin occludes the gate; may bounce.
REQ-009 coin  output  2  denomination code: 00=ten, 01=twenty, 10=fifty; 11 never driven.
REQ-010 coin_valid  output  1  one-cycle pulse qualifying coin.
REQ-011 coin_reject  output  1  one-cycle pulse when a pulse width matches no range.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 sense SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 The debounced level SHALL change only after the synchronized value differs from it for DB_CYCLES consecutive cycles; shorter glitches SHALL be ignored.
REQ-015 FSM states SHALL be IDLE, MEASURE, CLASSIFY, COOLDOWN; encoding is free.
REQ-016 IDLE -> MEASURE on the debounced rising edge; the width counter loads 1 on that cycle.
REQ-017 MEASURE: the width counter SHALL increment each cycle the debounced level is high, saturating at 16'hFFFF with no wrap.
REQ-018 MEASURE -> CLASSIFY on the debounced falling edge; width W = number of cycles the debounced level was high.
REQ-019 CLASSIFY SHALL last exactly one cycle and assert exactly one of coin_valid or coin_reject.
REQ-020 Range check order SHALL be ten, twenty, fifty; first match wins; inclusive bounds; no match (including saturated W) -> coin_reject.
REQ-021 coin SHALL update only in the coin_valid cycle and hold its value until the next coin_valid; on reject it holds its previous value.
REQ-022 CLASSIFY -> COOLDOWN for GAP_CYCLES cycles, then -> IDLE.
REQ-023 Debounced edges during COOLDOWN SHALL be ignored; if the debounced level is still high on the COOLDOWN exit cycle, the FSM stays in IDLE until a new rising edge.
REQ-024 Latency: coin_valid/coin_reject SHALL assert on the cycle after the debounced falling edge.
REQ-025 At most one coin_valid or coin_reject pulse SHALL be produced per debounced high pulse, and they SHALL never assert together.
REQ-026 busy SHALL be registered and high in MEASURE, CLASSIFY and COOLDOWN.

Reset
REQ-027 While reset is high: FSM=IDLE, synchronizer and debounced level=0, debounce and width counters=0, coin=00, coin_valid=0, coin_reject=0, busy=0.
REQ-028 Reset asserted mid-MEASURE SHALL discard the partial coin; no pulse is emitted after reset deassertion.
REQ-029 After reset deassertion, sense held high SHALL not register as a coin until it has gone low and then high again through the debouncer.

Verification
REQ-030 Clean 20-cycle high pulse on sense -> single coin_valid with coin=01, one cycle after the debounced fall; busy high from debounced rise through cooldown.
REQ-031 Pulses of 8, 15, 16, 63 and 64 debounced cycles, separated by more than GAP_CYCLES -> ten, ten, twenty, fifty, then coin_reject with coin still 10.
REQ-032 3-cycle glitches on sense while idle, plus a 3-cycle low dropout inside a 40-cycle pulse -> no output from the glitches; single coin=10 valid for the 40-cycle pulse.
REQ-033 Second 20-cycle pulse starting 2 cycles after the first coin_valid -> ignored; no second pulse; FSM returns to IDLE and waits for a new rising edge.
REQ-034 Reset asserted 10 cycles into a 40-cycle pulse, released while sense is still high -> all outputs 0 and no coin_valid or coin_reject; the next clean 12-cycle pulse -> coin=00 valid.
REQ-035 sense held high for 70000 cycles -> counter saturates at 16'hFFFF; coin_reject follows the fall; no wrap-around misclassification.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronizes and debounces the coin-gate sensor, measures the
// debounced high width and classifies it as ten/twenty/fifty or rejects it.
module coin_acceptor #(
  parameter int unsigned DB_CYCLES  = 4,
  parameter int unsigned W10_MIN    = 8,
  parameter int unsigned W10_MAX    = 15,
  parameter int unsigned W20_MIN    = 16,
  parameter int unsigned W20_MAX    = 31,
  parameter int unsigned W50_MIN    = 32,
  parameter int unsigned W50_MAX    = 63,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sense,
  output logic [1:0] coin,
  output logic       coin_valid,
  output logic       coin_reject,
  output logic       busy
);

  localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned GPW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [GPW-1:0] GAP_LAST = GPW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, CLASSIFY, COOLDOWN} state_t;

  state_t         state;
  logic           s1, s2;
  logic           db, db_prev;
  logic [DBW-1:0] db_cnt;
  logic           armed;
  logic [DBW-1:0] arm_cnt;
  logic [15:0]    width;
  logic [GPW-1:0] gap_cnt;
  logic           rise, fall;
  logic [31:0]    w;
  logic           cls_valid;
  logic [1:0]     cls_code;

  // Synchronizer, debouncer and arming. Arming needs a debounce-length run of
  // low samples, so a sensor already high when reset releases is never a coin.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      db      <= 1'b0;
      db_prev <= 1'b0;
      db_cnt  <= '0;
      armed   <= 1'b0;
      arm_cnt <= '0;
    end else begin
      s1      <= sense;
      s2      <= s1;
      db_prev <= db;
      if (s2 != db) begin
        if (db_cnt == DB_LAST) begin
          db     <= s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
      if (!armed) begin
        if (s2)
          arm_cnt <= '0;
        else if (arm_cnt == DB_LAST)
          armed <= 1'b1;
        else
          arm_cnt <= arm_cnt + 1'b1;
      end
    end
  end

  assign rise = db & ~db_prev & armed;
  assign fall = ~db & db_prev;
  assign w    = 32'(width);

  always_comb begin
    cls_valid = 1'b0;
    cls_code  = 2'b00;
    if (w >= W10_MIN && w <= W10_MAX) begin
      cls_valid = 1'b1;
      cls_code  = 2'b00;
    end else if (w >= W20_MIN && w <= W20_MAX) begin
      cls_valid = 1'b1;
      cls_code  = 2'b01;
    end else if (w >= W50_MIN && w <= W50_MAX) begin
      cls_valid = 1'b1;
      cls_code  = 2'b10;
    end
  end

  // Verdict is registered on the fall so the pulse coincides with CLASSIFY.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      width       <= '0;
      gap_cnt     <= '0;
      coin        <= 2'b00;
      coin_valid  <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      coin_valid  <= 1'b0;
      coin_reject <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= MEASURE;
            width <= 16'd1;
            busy  <= 1'b1;
          end
        end
        MEASURE: begin
          if (fall) begin
            state <= CLASSIFY;
            if (cls_valid) begin
              coin_valid <= 1'b1;
              coin       <= cls_code;
            end else begin
              coin_reject <= 1'b1;
            end
          end else if (db && width != 16'hFFFF) begin
            width <= width + 16'd1;
          end
        end
        CLASSIFY: begin
          state   <= COOLDOWN;
          gap_cnt <= '0;
        end
        COOLDOWN: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with hand-computed expectations.
module tb_coin_acceptor;

  logic       clock;
  logic       reset;
  logic       sense;
  logic [1:0] coin;
  logic       coin_valid;
  logic       coin_reject;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int nvalid = 0;
  int nrej = 0;

  coin_acceptor dut (
    .clock      (clock),
    .reset      (reset),
    .sense      (sense),
    .coin       (coin),
    .coin_valid (coin_valid),
    .coin_reject(coin_reject),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (coin_valid) nvalid++;
    if (coin_reject) nrej++;
    if (coin_valid || coin_reject)
      chk("exclusive", 32'(coin_valid & coin_reject), 32'd0);
  end

  // Sensor-to-pulse path is 2 sync + 4 debounce + 1 fall detect: the verdict
  // appears at the 8th falling clock edge after sense drops.
  task automatic run_coin(input int n, input int drop, input logic exp_rej,
                          input logic [1:0] exp_code, input string tag);
    int base;
    int lat;
    base = nvalid + nrej;
    @(posedge clock); #1 sense = 1'b1;
    if (drop > 0) begin
      repeat (drop) @(posedge clock);
      #1 sense = 1'b0;
      repeat (3) @(posedge clock);
      #1 sense = 1'b1;
      repeat (n - drop - 3) @(posedge clock);
    end else begin
      repeat (n) @(posedge clock);
    end
    #1 sense = 1'b0;
    @(negedge clock);
    chk({tag, "_busy_measure"}, 32'(busy), 32'd1);
    lat = 1;
    while (!(coin_valid || coin_reject) && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_valid"}, 32'(coin_valid), 32'(!exp_rej));
    chk({tag, "_reject"}, 32'(coin_reject), 32'(exp_rej));
    chk({tag, "_coin"}, 32'(coin), 32'(exp_code));
    chk({tag, "_busy_classify"}, 32'(busy), 32'd1);
    repeat (8) @(negedge clock);
    chk({tag, "_busy_cooldown_end"}, 32'(busy), 32'd1);
    @(negedge clock);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    repeat (4) @(negedge clock);
    chk({tag, "_pulse_count"}, 32'(nvalid + nrej - base), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int lat;
    reset = 1'b1;
    sense = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_coin", 32'(coin), 32'd0);
    chk("rst_valid", 32'(coin_valid), 32'd0);
    chk("rst_reject", 32'(coin_reject), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    repeat (10) @(posedge clock);

    run_coin(20, 0, 1'b0, 2'b01, "w20");
    run_coin(8,  0, 1'b0, 2'b00, "w8");
    run_coin(15, 0, 1'b0, 2'b00, "w15");
    run_coin(16, 0, 1'b0, 2'b01, "w16");
    run_coin(63, 0, 1'b0, 2'b10, "w63");
    run_coin(64, 0, 1'b1, 2'b10, "w64");

    // Short glitches while idle must be swallowed by the debouncer.
    base = nvalid + nrej;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1 sense = 1'b1;
      repeat (3) @(posedge clock);
      #1 sense = 1'b0;
      repeat (10) @(posedge clock);
    end
    @(negedge clock);
    chk("glitch_pulses", 32'(nvalid + nrej - base), 32'd0);
    chk("glitch_busy", 32'(busy), 32'd0);
    run_coin(40, 20, 1'b0, 2'b10, "dropout40");

    // Second pulse arrives during cooldown and is still high when it ends.
    base = nvalid + nrej;
    @(posedge clock); #1 sense = 1'b1;
    repeat (20) @(posedge clock);
    #1 sense = 1'b0;
    lat = 0;
    while (!(coin_valid || coin_reject) && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    chk("cool_first_valid", 32'(coin_valid), 32'd1);
    chk("cool_first_coin", 32'(coin), 32'd1);
    @(posedge clock);
    @(posedge clock);
    #1 sense = 1'b1;
    repeat (20) @(posedge clock);
    #1 sense = 1'b0;
    repeat (40) @(negedge clock);
    chk("cool_pulses", 32'(nvalid + nrej - base), 32'd1);
    chk("cool_busy", 32'(busy), 32'd0);
    run_coin(16, 0, 1'b0, 2'b01, "after_cool");

    // Reset in the middle of a coin, released while the sensor is still high.
    @(posedge clock); #1 sense = 1'b1;
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("midrst_coin", 32'(coin), 32'd0);
    chk("midrst_valid", 32'(coin_valid), 32'd0);
    chk("midrst_reject", 32'(coin_reject), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    base = nvalid + nrej;
    @(posedge clock); #1 reset = 1'b0;
    repeat (28) @(posedge clock);
    #1 sense = 1'b0;
    repeat (30) @(negedge clock);
    chk("midrst_pulses", 32'(nvalid + nrej - base), 32'd0);
    chk("midrst_busy_after", 32'(busy), 32'd0);
    chk("midrst_coin_after", 32'(coin), 32'd0);
    run_coin(12, 0, 1'b0, 2'b00, "w12_after_rst");

    run_coin(70000, 0, 1'b1, 2'b00, "saturate");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
